// File: rtl/div_operand_feeder_pkg.sv
// Shared constants, entry layout and per-cell transistor costs for the divider operand feeder.
package div_operand_feeder_pkg;

    localparam int unsigned A_W     = 8;
    localparam int unsigned B_W     = 5;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned ENTRY_W = A_W + B_W;
    localparam int unsigned NUM_W   = 51;

    // Transistor cost of each primitive cell used to build the feeder
    localparam int unsigned TR_DFF  = 20;   // plain D flop
    localparam int unsigned TR_DFFR = 24;   // D flop with async reset
    localparam int unsigned TR_MUX2 = 12;
    localparam int unsigned TR_AND2 = 6;
    localparam int unsigned TR_XOR2 = 12;
    localparam int unsigned TR_NOR2 = 4;

    typedef struct packed {
        logic [A_W-1:0] a;
        logic [B_W-1:0] b;
    } entry_t;

endpackage

// File: rtl/feeder_regfile.sv
// DEPTH x WIDTH storage of per-bit flip-flop cells, one write port and one
// combinational read port. Not reset.
module feeder_regfile #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 13
) (
    input  logic                                   clk,
    input  logic                                   i_we,
    input  logic [$clog2(DEPTH)-1:0]               i_wr_addr,
    input  logic [WIDTH-1:0]                       i_wr_data,
    input  logic [$clog2(DEPTH)-1:0]               i_rd_addr,
    output logic [WIDTH-1:0]                       o_rd_data,
    output logic [div_operand_feeder_pkg::NUM_W-1:0] number
);
    import div_operand_feeder_pkg::*;

    // Per bit: storage flop plus hold mux; read tree; one row-enable gate per row
    localparam int unsigned RF_TR = DEPTH * WIDTH * (TR_DFF + TR_MUX2)
                                  + (DEPTH - 1) * WIDTH * TR_MUX2
                                  + DEPTH * TR_AND2;

    logic [DEPTH-1:0]            row_sel;
    logic [DEPTH-1:0][WIDTH-1:0] rows;

    always_comb begin
        row_sel = '0;
        if (i_we) begin
            row_sel[i_wr_addr] = 1'b1;
        end
    end

    for (genvar r = 0; r < DEPTH; r++) begin : g_row
        for (genvar c = 0; c < WIDTH; c++) begin : g_bit
            logic bit_q;
            always_ff @(posedge clk) begin
                if (row_sel[r]) begin
                    bit_q <= i_wr_data[c];
                end
            end
            assign rows[r][c] = bit_q;
        end
    end

    assign o_rd_data = rows[i_rd_addr];
    assign number    = NUM_W'(RF_TR);

endmodule

// File: rtl/div_operand_feeder.sv
// Divider front end: buffers dividend/divisor pairs in a small FIFO, drops
// zero divisors, and issues one registered pair per cycle to the divider.
module div_operand_feeder #(
    parameter int unsigned DEPTH = div_operand_feeder_pkg::DEPTH,
    parameter int unsigned A_W   = div_operand_feeder_pkg::A_W,
    parameter int unsigned B_W   = div_operand_feeder_pkg::B_W
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   i_valid,
    output logic                                   o_ready,
    input  logic [A_W-1:0]                         i_a,
    input  logic [B_W-1:0]                         i_b,
    input  logic                                   i_clear,
    input  logic                                   i_div_ready,
    output logic                                   o_in_valid,
    output logic [A_W-1:0]                         o_a,
    output logic [B_W-1:0]                         o_b,
    output logic                                   o_dz_err,
    output logic [$clog2(DEPTH):0]                 o_count,
    output logic [div_operand_feeder_pkg::NUM_W-1:0] number
);
    import div_operand_feeder_pkg::*;

    localparam int unsigned FIFO_PTR_W = $clog2(DEPTH);
    localparam int unsigned FIFO_CNT_W = FIFO_PTR_W + 1;
    localparam int unsigned ENTRY_BITS = A_W + B_W;

    // Reset flops, output hold muxes, pointer/count arithmetic, zero/full detect, handshake
    localparam int unsigned TOP_TR = (2 * FIFO_PTR_W + FIFO_CNT_W + 2 + ENTRY_BITS) * TR_DFFR
                                   + ENTRY_BITS * TR_MUX2
                                   + 2 * FIFO_PTR_W * TR_XOR2
                                   + FIFO_CNT_W * 2 * TR_XOR2
                                   + B_W * TR_NOR2
                                   + FIFO_CNT_W * TR_XOR2
                                   + 4 * TR_AND2;

    logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_CNT_W-1:0] count_q, count_d;
    logic [ENTRY_BITS-1:0] rd_data;
    logic [NUM_W-1:0]      rf_number;
    logic                  accept, b_zero, dz_d, wr_en, pop;

    assign o_ready = (count_q != FIFO_CNT_W'(DEPTH));
    assign o_count = count_q;

    always_comb begin
        accept   = i_valid & o_ready;
        b_zero   = (i_b == '0);
        dz_d     = accept & b_zero;
        wr_en    = accept & ~b_zero & ~i_clear;
        pop      = (count_q != '0) & i_div_ready & ~i_clear;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + FIFO_PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + FIFO_PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_d = count_q + FIFO_CNT_W'(1);
                2'b01:   count_d = count_q - FIFO_CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            o_in_valid <= 1'b0;
            o_a        <= '0;
            o_b        <= '0;
            o_dz_err   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            o_in_valid <= pop;
            o_dz_err   <= dz_d;
            if (pop) begin
                o_a <= rd_data[ENTRY_BITS-1:B_W];
                o_b <= rd_data[B_W-1:0];
            end
        end
    end

    feeder_regfile #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_BITS)
    ) u_regfile (
        .clk       (clk),
        .i_we      (wr_en),
        .i_wr_addr (wr_ptr_q),
        .i_wr_data ({i_a, i_b}),
        .i_rd_addr (rd_ptr_q),
        .o_rd_data (rd_data),
        .number    (rf_number)
    );

    assign number = rf_number + NUM_W'(TOP_TR);

endmodule

// File: tb/tb_div_operand_feeder.sv
// Self-checking bench for div_operand_feeder: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_div_operand_feeder;
    import div_operand_feeder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_a;
    logic [4:0]  i_b;
    logic        i_clear;
    logic        i_div_ready;
    logic        o_in_valid;
    logic [7:0]  o_a;
    logic [4:0]  o_b;
    logic        o_dz_err;
    logic [2:0]  o_count;
    logic [50:0] number;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    entry_t     q[$];
    logic       m_valid, m_dz;
    logic [7:0] m_a;
    logic [4:0] m_b;
    logic       last_acc;

    typedef struct {
        logic       v;
        logic [7:0] a;
        logic [4:0] b;
        logic       rdy;
        logic       e_iv;
        logic [7:0] e_a;
        logic [4:0] e_b;
        logic       e_dz;
        logic [2:0] e_cnt;
        logic       e_rdy;
    } vec_t;

    vec_t vecs[21];

    div_operand_feeder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_clear     (i_clear),
        .i_div_ready (i_div_ready),
        .o_in_valid  (o_in_valid),
        .o_a         (o_a),
        .o_b         (o_b),
        .o_dz_err    (o_dz_err),
        .o_count     (o_count),
        .number      (number)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_valid = 1'b0;
        m_dz    = 1'b0;
        m_a     = '0;
        m_b     = '0;
    endtask

    // Drive one cycle, advance the model across the edge, compare just after it
    task automatic cycle(input logic v, input logic [7:0] a, input logic [4:0] b,
                         input logic clr, input logic rdy);
        entry_t e;
        i_valid     = v;
        i_a         = a;
        i_b         = b;
        i_clear     = clr;
        i_div_ready = rdy;
        last_acc = v && (q.size() != DEPTH);
        m_dz     = last_acc && (b == 0);
        m_valid  = 1'b0;
        if (clr) begin
            q.delete();
        end else begin
            if (rdy && q.size() != 0) begin
                e       = q.pop_front();
                m_valid = 1'b1;
                m_a     = e.a;
                m_b     = e.b;
            end
            if (last_acc && b != 0) begin
                e.a = a;
                e.b = b;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        check("in_valid", o_in_valid, m_valid);
        check("a", o_a, m_a);
        check("b", o_b, m_b);
        check("dz_err", o_dz_err, m_dz);
        check("count", o_count, q.size());
        check("ready", o_ready, q.size() != DEPTH);
    endtask

    initial begin
        logic       rv, held;
        logic [7:0] ra;
        logic [4:0] rb;

        vecs[0]  = '{1, 200, 7, 1,  0, 0,   0, 0, 1, 1};
        vecs[1]  = '{0, 0,   0, 1,  1, 200, 7, 0, 0, 1};
        vecs[2]  = '{0, 0,   0, 1,  0, 200, 7, 0, 0, 1};
        vecs[3]  = '{1, 10,  1, 0,  0, 200, 7, 0, 1, 1};
        vecs[4]  = '{1, 11,  2, 0,  0, 200, 7, 0, 2, 1};
        vecs[5]  = '{1, 12,  3, 0,  0, 200, 7, 0, 3, 1};
        vecs[6]  = '{1, 13,  4, 0,  0, 200, 7, 0, 4, 0};
        vecs[7]  = '{1, 14,  5, 0,  0, 200, 7, 0, 4, 0};
        vecs[8]  = '{1, 14,  5, 1,  1, 10,  1, 0, 3, 1};
        vecs[9]  = '{1, 14,  5, 1,  1, 11,  2, 0, 3, 1};
        vecs[10] = '{0, 0,   0, 1,  1, 12,  3, 0, 2, 1};
        vecs[11] = '{0, 0,   0, 1,  1, 13,  4, 0, 1, 1};
        vecs[12] = '{0, 0,   0, 1,  1, 14,  5, 0, 0, 1};
        vecs[13] = '{0, 0,   0, 1,  0, 14,  5, 0, 0, 1};
        vecs[14] = '{1, 99,  0, 1,  0, 14,  5, 1, 0, 1};
        vecs[15] = '{1, 99,  3, 1,  0, 14,  5, 0, 1, 1};
        vecs[16] = '{0, 0,   0, 1,  1, 99,  3, 0, 0, 1};
        vecs[17] = '{0, 0,   0, 1,  0, 99,  3, 0, 0, 1};
        vecs[18] = '{1, 7,   0, 1,  0, 99,  3, 1, 0, 1};
        vecs[19] = '{1, 8,   0, 1,  0, 99,  3, 1, 0, 1};
        vecs[20] = '{0, 0,   0, 1,  0, 99,  3, 0, 0, 1};

        rst_n       = 1'b0;
        i_valid     = 1'b0;
        i_a         = '0;
        i_b         = '0;
        i_clear     = 1'b0;
        i_div_ready = 1'b0;
        model_reset();
        #12;
        check("rst_in_valid", o_in_valid, 0);
        check("rst_a", o_a, 0);
        check("rst_b", o_b, 0);
        check("rst_dz_err", o_dz_err, 0);
        check("rst_count", o_count, 0);
        rst_n = 1'b1;
        #1;
        check("rst_ready", o_ready, 1);
        check("number", number, 51'd3040);

        // Directed table: single issue latency, fill/backpressure, zero divisors
        for (int i = 0; i < 21; i++) begin
            cycle(vecs[i].v, vecs[i].a, vecs[i].b, 1'b0, vecs[i].rdy);
            check("tbl_in_valid", o_in_valid, vecs[i].e_iv);
            check("tbl_a", o_a, vecs[i].e_a);
            check("tbl_b", o_b, vecs[i].e_b);
            check("tbl_dz_err", o_dz_err, vecs[i].e_dz);
            check("tbl_count", o_count, vecs[i].e_cnt);
            check("tbl_ready", o_ready, vecs[i].e_rdy);
        end

        // Steady push+pop at occupancy 2 across pointer wrap
        cycle(1'b1, 8'd100, 5'd1, 1'b0, 1'b0);
        cycle(1'b1, 8'd101, 5'd2, 1'b0, 1'b0);
        for (int k = 2; k < 18; k++) begin
            cycle(1'b1, 8'(100 + k), 5'(k % 31 + 1), 1'b0, 1'b1);
            check("steady_count", o_count, 2);
            check("steady_a", o_a, 100 + k - 2);
        end
        for (int k = 0; k < 3; k++) cycle(1'b0, 8'd0, 5'd0, 1'b0, 1'b1);

        // Clear with three queued pairs and a simultaneous offer
        cycle(1'b1, 8'd60, 5'd1, 1'b0, 1'b0);
        cycle(1'b1, 8'd61, 5'd2, 1'b0, 1'b0);
        cycle(1'b1, 8'd62, 5'd3, 1'b0, 1'b0);
        cycle(1'b1, 8'd50, 5'd5, 1'b1, 1'b1);
        check("clear_count", o_count, 0);
        check("clear_in_valid", o_in_valid, 0);
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 8'd0, 5'd0, 1'b0, 1'b1);
            check("clear_no_issue", o_in_valid, 0);
        end

        // Asynchronous reset while an issue is on the outputs
        cycle(1'b1, 8'd77, 5'd9, 1'b0, 1'b1);
        cycle(1'b0, 8'd0, 5'd0, 1'b0, 1'b1);
        check("pre_rst_in_valid", o_in_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_valid", o_in_valid, 0);
        check("arst_a", o_a, 0);
        check("arst_b", o_b, 0);
        check("arst_count", o_count, 0);
        check("arst_dz_err", o_dz_err, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", o_ready, 1);
        check("post_rst_count", o_count, 0);

        // Randomized traffic; producer holds a refused pair stable
        held = 1'b0;
        rv   = 1'b0;
        ra   = '0;
        rb   = '0;
        for (int n = 0; n < 500; n++) begin
            if (!held) begin
                rv = ($urandom_range(0, 3) != 0);
                ra = 8'($urandom);
                rb = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            end
            cycle(rv, ra, rb, ($urandom_range(0, 31) == 0), ($urandom_range(0, 2) != 0));
            held = rv && !last_acc;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
